axi_burst_traffic_gen: RTL and testbench

//  Synthesizable AXI4 full-protocol master used to exercise and self-check AXI slaves (e.g. axi_slave).
//  Per run: NUM_BURSTS x (INCR write burst, wait B, INCR read-back burst, compare).

---
 rtl/axi_burst_traffic_gen_pkg.sv | 19 +
 rtl/axi_burst_traffic_gen_lfsr.sv | 27 ++
 rtl/axi_burst_traffic_gen.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_burst_traffic_gen.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_traffic_gen_pkg.sv
// Shared constants for the AXI burst traffic generator.
// AXI encodings, FSM state codes and throttle LFSR taps.
package axi_burst_traffic_gen_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axi_burst_traffic_gen_lfsr.sv
// 16-bit Galois LFSR producing the valid/ready throttle gate.
// Advances every cycle; gate is the current LSB.
module axi_tg_lfsr
    import axi_burst_traffic_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic gate_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign gate_o = lfsr_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/axi_burst_traffic_gen.sv
// AXI4 master: per run, NUM_BURSTS x (INCR write, B, INCR read-back, compare).
// One burst outstanding; sticky error flag and saturating error count.
module axi_burst_traffic_gen
    import axi_burst_traffic_gen_pkg::*;
#(
    parameter int          C_M_AXI_ID_WIDTH   = 2,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          C_M_AXI_ADDR_WIDTH = 5,
    parameter int          BURST_LEN          = 8,
    parameter int          NUM_BURSTS         = 4,
    parameter int          ADDR_BASE          = 0,
    parameter bit          OPT_THROTTLE       = 1'b0,
    parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [15:0]                       err_count,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int IW = C_M_AXI_ID_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int BW = $clog2(NUM_BURSTS) + 1;
    localparam int BURST_BYTES = BURST_LEN * (DW / 8);

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [8:0]    beat_q, beat_d;
    logic [15:0]   tag_q, tag_d;
    logic [15:0]   errcnt_q, errcnt_d;
    logic          error_q, error_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          arvalid_q, arvalid_d;
    logic          gate;

    if (OPT_THROTTLE) begin : g_lfsr
        axi_tg_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
            .clk_i (M_AXI_ACLK),
            .rst_ni(M_AXI_ARESETN),
            .gate_o(gate)
        );
    end else begin : g_nolfsr
        assign gate = 1'b1;
    end

    logic          last_beat, last_burst;
    logic [IW-1:0] exp_id;
    logic [31:0]   idx, offs;
    logic [DW-1:0] tag_rep, pattern;
    logic [AW-1:0] addr;
    logic          bhs, rhs, b_bad, r_bad, bump;

    assign last_beat  = (beat_q == 9'(BURST_LEN - 1));
    assign last_burst = (burst_q == BW'(NUM_BURSTS - 1));
    assign exp_id     = IW'(burst_q);
    assign idx        = 32'(burst_q) * 32'(BURST_LEN) + 32'(beat_q);
    assign offs       = 32'(burst_q) * 32'(BURST_BYTES);
    assign addr       = AW'(32'(ADDR_BASE) + offs);

    always_comb begin
        tag_rep = '0;
        for (int i = 0; i < DW; i++) begin
            tag_rep[i] = tag_q[i % 16];
        end
    end

    assign pattern = DW'(idx) ^ tag_rep;

    assign bhs   = M_AXI_BVALID && M_AXI_BREADY;
    assign rhs   = M_AXI_RVALID && M_AXI_RREADY;
    assign b_bad = (M_AXI_BRESP != RESP_OKAY) || (M_AXI_BID != exp_id);
    assign r_bad = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RID != exp_id) ||
                   (M_AXI_RDATA != pattern) || (M_AXI_RLAST != last_beat);
    assign bump  = (bhs && b_bad) || (rhs && r_bad);

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        tag_d     = tag_q;
        errcnt_d  = errcnt_q;
        error_d   = error_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;

        if (bump) begin
            error_d = 1'b1;
            if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_AW;
                    burst_d  = '0;
                    beat_d   = '0;
                    error_d  = 1'b0;
                    errcnt_d = '0;
                end
            end
            S_AW: begin
                if (!awvalid_q) begin
                    awvalid_d = gate;
                end else if (M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    state_d   = S_W;
                end
            end
            S_W: begin
                if (!wvalid_q) begin
                    wvalid_d = gate;
                end else if (M_AXI_WREADY) begin
                    beat_d   = beat_q + 9'd1;
                    wvalid_d = !last_beat && gate;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (bhs) state_d = S_AR;
            end
            S_AR: begin
                if (!arvalid_q) begin
                    arvalid_d = gate;
                end else if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R;
                end
            end
            S_R: begin
                // burst ends on beat count; a missing RLAST is only flagged
                if (rhs) begin
                    beat_d = beat_q + 9'd1;
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            state_d = S_DONE;
                        end else begin
                            burst_d = burst_q + BW'(1);
                            state_d = S_AW;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                tag_d   = tag_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            burst_q   <= '0;
            beat_q    <= '0;
            tag_q     <= '0;
            errcnt_q  <= '0;
            error_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            tag_q     <= tag_d;
            errcnt_q  <= errcnt_d;
            error_q   <= error_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign error     = error_q;
    assign err_count = errcnt_q;

    assign M_AXI_AWID    = exp_id;
    assign M_AXI_AWADDR  = addr;
    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = awvalid_q;

    assign M_AXI_WDATA  = pattern;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_WLAST  = last_beat;
    assign M_AXI_WVALID = wvalid_q;

    assign M_AXI_BREADY = (state_q == S_B) && gate;

    assign M_AXI_ARID    = exp_id;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARVALID = arvalid_q;

    assign M_AXI_RREADY = (state_q == S_R) && gate;

endmodule

// File: tb/tb_axi_burst_traffic_gen.sv
// Directed bench: two generators (plain / throttled) each on a small AXI slave model.
// Instance 0 also gets read-data/response corruption and a mid-burst reset.
module tb_axi_burst_traffic_gen;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] inj_v;
    logic [1:0] done_v, busy_v, error_v;
    logic [1:0][15:0] errc_v;
    int         cyc;
    int         act;
    int         n_chk;
    int         n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_tb
        logic        busy, done, error;
        logic [15:0] err_count;
        logic [1:0]  awid, bid, arid, rid, bresp, rresp;
        logic [4:0]  awaddr, araddr;
        logic [7:0]  awlen, arlen;
        logic [2:0]  awsize, arsize;
        logic [1:0]  awburst, arburst;
        logic        awvalid, wvalid, bvalid, arvalid, rvalid;
        logic        awready, wready, bready, arready, rready;
        logic [31:0] wdata, rdata;
        logic [3:0]  wstrb;
        logic        wlast, rlast;
        logic        sready;
        logic [31:0] mem [8];
        logic [2:0]  wa, ra;
        logic [1:0]  wid_q;
        logic [3:0]  rbeat;
        int          wbeats;
        int          proto_err;
        int          hold_viol;
        logic [7:0]  bid_log, rid_log;
        logic [4:0]  addr_or;
        logic        paw, pw, par;
        logic [4:0]  paw_a, par_a;
        logic [32:0] pw_d;

        assign sready  = (g == 0) ? 1'b1 : ((cyc % 3) != 0);
        assign awready = sready;
        assign wready  = sready;
        assign arready = sready;
        assign bresp   = 2'b00;
        assign rlast   = (rbeat == 4'd7);
        assign rdata   = mem[ra] ^
            ((inj_v[g] && rid == 2'd0 && rbeat == 4'd3) ? 32'h0000_0100 : 32'h0);
        assign rresp   = (inj_v[g] && rid == 2'd0 && rbeat == 4'd5) ? 2'b10 : 2'b00;

        assign done_v[g]  = done;
        assign busy_v[g]  = busy;
        assign error_v[g] = error;
        assign errc_v[g]  = err_count;

        axi_burst_traffic_gen #(
            .C_M_AXI_ID_WIDTH  (2),
            .C_M_AXI_DATA_WIDTH(32),
            .C_M_AXI_ADDR_WIDTH(5),
            .BURST_LEN         (8),
            .NUM_BURSTS        (4),
            .ADDR_BASE         (0),
            .OPT_THROTTLE      (g == 1 ? 1'b1 : 1'b0),
            .LFSR_SEED         (16'hACE1)
        ) u_dut (
            .M_AXI_ACLK   (clk),
            .M_AXI_ARESETN(rst_n),
            .start        (start_v[g]),
            .busy         (busy),
            .done         (done),
            .error        (error),
            .err_count    (err_count),
            .M_AXI_AWID   (awid),
            .M_AXI_AWADDR (awaddr),
            .M_AXI_AWLEN  (awlen),
            .M_AXI_AWSIZE (awsize),
            .M_AXI_AWBURST(awburst),
            .M_AXI_AWVALID(awvalid),
            .M_AXI_AWREADY(awready),
            .M_AXI_WDATA  (wdata),
            .M_AXI_WSTRB  (wstrb),
            .M_AXI_WLAST  (wlast),
            .M_AXI_WVALID (wvalid),
            .M_AXI_WREADY (wready),
            .M_AXI_BID    (bid),
            .M_AXI_BRESP  (bresp),
            .M_AXI_BVALID (bvalid),
            .M_AXI_BREADY (bready),
            .M_AXI_ARID   (arid),
            .M_AXI_ARADDR (araddr),
            .M_AXI_ARLEN  (arlen),
            .M_AXI_ARSIZE (arsize),
            .M_AXI_ARBURST(arburst),
            .M_AXI_ARVALID(arvalid),
            .M_AXI_ARREADY(arready),
            .M_AXI_RID    (rid),
            .M_AXI_RDATA  (rdata),
            .M_AXI_RRESP  (rresp),
            .M_AXI_RLAST  (rlast),
            .M_AXI_RVALID (rvalid),
            .M_AXI_RREADY (rready)
        );

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bvalid <= 1'b0;
                rvalid <= 1'b0;
                bid    <= '0;
                rid    <= '0;
                wa     <= '0;
                ra     <= '0;
                wid_q  <= '0;
                rbeat  <= '0;
                wbeats <= 0;
                paw    <= 1'b0;
                pw     <= 1'b0;
                par    <= 1'b0;
            end else begin
                if (awvalid && awready) begin
                    wa      <= awaddr[4:2];
                    wid_q   <= awid;
                    addr_or <= addr_or | awaddr;
                    if (awlen != 8'd7 || awsize != 3'd2 || awburst != 2'b01)
                        proto_err <= proto_err + 1;
                end
                if (wvalid && wready) begin
                    mem[wa] <= wdata;
                    wa      <= wa + 3'd1;
                    wbeats  <= wlast ? 0 : wbeats + 1;
                    if (wlast != (wbeats == 7) || wstrb != 4'hF)
                        proto_err <= proto_err + 1;
                    if (wlast) begin
                        bvalid <= 1'b1;
                        bid    <= wid_q;
                    end
                end
                if (bvalid && bready) begin
                    bvalid  <= 1'b0;
                    bid_log <= {bid_log[5:0], bid};
                end
                if (arvalid && arready) begin
                    ra      <= araddr[4:2];
                    rid     <= arid;
                    rbeat   <= '0;
                    rvalid  <= 1'b1;
                    rid_log <= {rid_log[5:0], arid};
                    addr_or <= addr_or | araddr;
                    if (arlen != 8'd7 || arsize != 3'd2 || arburst != 2'b01)
                        proto_err <= proto_err + 1;
                end
                if (rvalid && rready) begin
                    ra    <= ra + 3'd1;
                    rbeat <= rbeat + 4'd1;
                    if (rbeat == 4'd7) rvalid <= 1'b0;
                end
                // a pending valid must stay up with the same payload
                if ((paw && (!awvalid || awaddr != paw_a)) ||
                    (pw && (!wvalid || {wlast, wdata} != pw_d)) ||
                    (par && (!arvalid || araddr != par_a)))
                    hold_viol <= hold_viol + 1;
                paw   <= awvalid && !awready;
                paw_a <= awaddr;
                pw    <= wvalid && !wready;
                pw_d  <= {wlast, wdata};
                par   <= arvalid && !arready;
                par_a <= araddr;
            end
        end

        initial begin
            proto_err = 0;
            hold_viol = 0;
            bid_log   = '0;
            rid_log   = '0;
            addr_or   = '0;
        end
    end

    always @(posedge clk) begin
        if (g_tb[0].awvalid || g_tb[0].wvalid || g_tb[0].arvalid || busy_v[0] ||
            g_tb[1].awvalid || g_tb[1].wvalid || g_tb[1].arvalid || busy_v[1])
            act <= act + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic run_one(input int g, input bit poke);
        int n;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        n = 0;
        while (!done_v[g] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'b0, done_v[g]}, 32'd1);
        if (poke) begin
            // start raised during the DONE cycle must be ignored
            start_v[g] = 1'b1;
            @(negedge clk);
            start_v[g] = 1'b0;
            chk("start_in_done", {31'b0, busy_v[g]}, 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int a0, n;
        n_chk   = 0;
        n_err   = 0;
        cyc     = 0;
        act     = 0;
        rst_n   = 1'b0;
        start_v = '0;
        inj_v   = '0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", {31'b0, g_tb[0].awvalid}, 32'd0);
        chk("rst_wvalid", {31'b0, g_tb[0].wvalid}, 32'd0);
        chk("rst_arvalid", {31'b0, g_tb[0].arvalid}, 32'd0);
        chk("rst_ready", {30'b0, g_tb[0].bready, g_tb[0].rready}, 32'd0);
        chk("rst_flags", {29'b0, busy_v[0], done_v[0], error_v[0]}, 32'd0);
        chk("rst_errc", {16'b0, errc_v[0]}, 32'd0);
        chk("rst_flags1", {29'b0, busy_v[1], done_v[1], error_v[1]}, 32'd0);
        rst_n = 1'b1;

        a0 = act;
        repeat (2000) @(negedge clk);
        chk("idle_activity", act - a0, 32'd0);

        run_one(0, 1'b1);
        chk("r1_error", {31'b0, error_v[0]}, 32'd0);
        chk("r1_errc", {16'b0, errc_v[0]}, 32'd0);
        for (int i = 0; i < 8; i++) chk("r1_mem", g_tb[0].mem[i], 32'(24 + i));
        chk("r1_bids", {24'b0, g_tb[0].bid_log}, 32'h1B);
        chk("r1_rids", {24'b0, g_tb[0].rid_log}, 32'h1B);
        chk("r1_addr", {27'b0, g_tb[0].addr_or}, 32'd0);
        chk("r1_proto", g_tb[0].proto_err, 32'd0);

        run_one(1, 1'b0);
        chk("thr_error", {31'b0, error_v[1]}, 32'd0);
        chk("thr_errc", {16'b0, errc_v[1]}, 32'd0);
        for (int i = 0; i < 8; i++) chk("thr_mem", g_tb[1].mem[i], 32'(24 + i));
        chk("thr_bids", {24'b0, g_tb[1].bid_log}, 32'h1B);
        chk("thr_hold", g_tb[1].hold_viol, 32'd0);
        chk("thr_proto", g_tb[1].proto_err, 32'd0);

        inj_v[0] = 1'b1;
        run_one(0, 1'b0);
        inj_v[0] = 1'b0;
        chk("inj_errc", {16'b0, errc_v[0]}, 32'd2);
        chk("inj_error", {31'b0, error_v[0]}, 32'd1);
        for (int i = 0; i < 8; i++)
            chk("inj_mem", g_tb[0].mem[i], 32'(24 + i) ^ 32'h0001_0001);
        repeat (20) @(negedge clk);
        chk("inj_sticky", {31'b0, error_v[0]}, 32'd1);

        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while (!(g_tb[0].wbeats == 4 && g_tb[0].wvalid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached", {31'b0, g_tb[0].wvalid}, 32'd1);
        chk("clr_error", {31'b0, error_v[0]}, 32'd0);
        chk("clr_errc", {16'b0, errc_v[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_valid",
            {29'b0, g_tb[0].awvalid, g_tb[0].wvalid, g_tb[0].arvalid}, 32'd0);
        chk("abort_busy", {30'b0, busy_v[0], done_v[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_one(0, 1'b1);
        chk("post_error", {31'b0, error_v[0]}, 32'd0);
        chk("post_errc", {16'b0, errc_v[0]}, 32'd0);
        for (int i = 0; i < 8; i++) chk("post_mem", g_tb[0].mem[i], 32'(24 + i));
        chk("post_hold0", g_tb[0].hold_viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
